tmr_apb4_sched: RTL and testbench

- APB4 master that shares one APB4 timer instance among NUM_REQ hardware requesters, each asking for a one-shot timeout.
- Arbitrates round-robin, then programs the timer in order: PSCR, CMP, CTRL (enable + overflow IRQ).
- Waits for the timer interrupt, clears it by reading STAT, disables the timer, and returns done/err to the granted requester.
- Sits between requester logic and the timer's APB4 slave port; it is the only master on that port.

---
 rtl/tmr_apb4_sched.sv | 187 ++++++++++++++++++
 tb/tb_tmr_apb4_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_apb4_sched.sv
// APB4 master that time-shares one timer among NUM_REQ one-shot timeout requesters.
// Round-robin grant, program PSCR/CMP/CTRL, wait for IRQ (with watchdog), clear, disable, report.
module tmr_apb4_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PSCR_WIDTH = 20,
  parameter int unsigned CMP_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic [31:0] TMO_CYC    = 32'hFFFF_FFFF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*PSCR_WIDTH-1:0] pscr_i,
  input  logic [NUM_REQ*CMP_WIDTH-1:0]  cmp_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic                          err_o,
  output logic                          busy_o,
  input  logic                          irq_i,
  output logic [31:0]                   paddr_o,
  output logic                          psel_o,
  output logic                          penable_o,
  output logic                          pwrite_o,
  output logic [31:0]                   pwdata_o,
  input  logic [31:0]                   prdata_i,
  input  logic                          pready_i,
  input  logic                          pslverr_i
);

  localparam int unsigned IDX_W    = $clog2(NUM_REQ);
  localparam logic [31:0] OFF_CTRL = 32'h00;
  localparam logic [31:0] OFF_PSCR = 32'h04;
  localparam logic [31:0] OFF_CMP  = 32'h0C;
  localparam logic [31:0] OFF_STAT = 32'h10;
  localparam logic [31:0] CTRL_ARM = 32'h5;

  typedef enum logic [2:0] {
    IDLE, WR_PSCR, WR_CMP, WR_CTRL, WAIT_IRQ, RD_STAT, WR_DIS, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [PSCR_WIDTH-1:0]   pscr_q, pscr_d;
  logic [CMP_WIDTH-1:0]    cmp_q, cmp_d;
  logic [31:0]             wdog_q, wdog_d;
  logic                    sticky_q, sticky_d;
  logic [NUM_REQ-1:0]      gnt_d, done_d;
  logic                    err_d, busy_d;
  logic [31:0]             paddr_d, pwdata_d;
  logic                    psel_d, penable_d, pwrite_d;
  logic                    xfer_done;
  logic                    found;
  logic [IDX_W-1:0]        win, cand;

  // Read data carries nothing we need: reading STAT is only to clear the IRQ.
  logic unused_prdata;
  assign unused_prdata = ^prdata_i;

  // Round-robin pick: first requester after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pscr_d    = pscr_q;
    cmp_d     = cmp_q;
    wdog_d    = wdog_q;
    sticky_d  = sticky_q;
    gnt_d     = gnt_o;
    done_d    = '0;
    err_d     = 1'b0;
    paddr_d   = '0;
    pwdata_d  = '0;
    xfer_done = psel_o && penable_o && pready_i;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = WR_PSCR;
          ptr_d   = win;
          gnt_d   = NUM_REQ'(1) << win;
          pscr_d  = PSCR_WIDTH'(pscr_i >> (32'(win) * PSCR_WIDTH));
          cmp_d   = CMP_WIDTH'(cmp_i >> (32'(win) * CMP_WIDTH));
        end
      end
      WR_PSCR: if (xfer_done) state_d = pslverr_i ? WR_DIS : WR_CMP;
      WR_CMP:  if (xfer_done) state_d = pslverr_i ? WR_DIS : WR_CTRL;
      WR_CTRL: begin
        if (xfer_done) begin
          state_d = pslverr_i ? WR_DIS : WAIT_IRQ;
          wdog_d  = TMO_CYC;
        end
      end
      // IRQ has priority over a watchdog expiry in the same cycle.
      WAIT_IRQ: begin
        if (irq_i) begin
          state_d = RD_STAT;
        end else if (TMO_CYC != 32'd0) begin
          if (wdog_q <= 32'd1) begin
            sticky_d = 1'b1;
            state_d  = WR_DIS;
          end else begin
            wdog_d = wdog_q - 32'd1;
          end
        end
      end
      RD_STAT: if (xfer_done) state_d = WR_DIS;
      WR_DIS:  if (xfer_done) state_d = DONE;
      DONE: begin
        sticky_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (xfer_done && pslverr_i) sticky_d = 1'b1;

    if (state_q == WR_DIS && state_d == DONE) begin
      done_d = gnt_o;
      gnt_d  = '0;
      err_d  = sticky_d;
    end

    // Bus outputs are derived from the next state so they appear registered.
    busy_d    = (state_d != IDLE);
    psel_d    = state_d inside {WR_PSCR, WR_CMP, WR_CTRL, RD_STAT, WR_DIS};
    penable_d = psel_o && !xfer_done;
    pwrite_d  = psel_d && (state_d != RD_STAT);

    case (state_d)
      WR_PSCR: begin paddr_d = BASE_ADDR + OFF_PSCR; pwdata_d = 32'(pscr_d); end
      WR_CMP:  begin paddr_d = BASE_ADDR + OFF_CMP;  pwdata_d = 32'(cmp_d);  end
      WR_CTRL: begin paddr_d = BASE_ADDR + OFF_CTRL; pwdata_d = CTRL_ARM;    end
      RD_STAT: begin paddr_d = BASE_ADDR + OFF_STAT; pwdata_d = '0;          end
      WR_DIS:  begin paddr_d = BASE_ADDR + OFF_CTRL; pwdata_d = '0;          end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      pscr_q    <= '0;
      cmp_q     <= '0;
      wdog_q    <= '0;
      sticky_q  <= 1'b0;
      gnt_o     <= '0;
      done_o    <= '0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      paddr_o   <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pscr_q    <= pscr_d;
      cmp_q     <= cmp_d;
      wdog_q    <= wdog_d;
      sticky_q  <= sticky_d;
      gnt_o     <= gnt_d;
      done_o    <= done_d;
      err_o     <= err_d;
      busy_o    <= busy_d;
      paddr_o   <= paddr_d;
      psel_o    <= psel_d;
      penable_o <= penable_d;
      pwrite_o  <= pwrite_d;
      pwdata_o  <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_tmr_apb4_sched.sv
// Scoreboard bench for tmr_apb4_sched: stimulus pushes expected APB transfers and done
// events; a negedge monitor pops and compares, a small APB slave/timer model responds.
module tb_tmr_apb4_sched;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } apb_t;

  typedef struct packed {
    logic [3:0] vec;
    logic       err;
  } done_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [79:0]  pscr;
  logic [127:0] cmp;
  logic [3:0]   gnt, done;
  logic         err, busy, irq;
  logic [31:0]  paddr, pwdata, prdata;
  logic         psel, penable, pwrite, pready, pslverr;

  always #5 clk = ~clk;

  tmr_apb4_sched #(
    .NUM_REQ(4), .PSCR_WIDTH(20), .CMP_WIDTH(32),
    .BASE_ADDR(32'h0), .TMO_CYC(32'd20)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .pscr_i(pscr), .cmp_i(cmp),
    .gnt_o(gnt), .done_o(done), .err_o(err), .busy_o(busy), .irq_i(irq),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  apb_t  apb_q[$];
  done_t done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // APB slave + timer model: wait states, address-matched slave error, IRQ after arm.
  int          ws = 0;
  logic        err_on = 1'b0;
  logic [31:0] err_addr = '0;
  int          irq_dly = 0;
  int          irq_cnt = 0;
  int          acc_cnt = 0;
  int          t_irq = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pready = 1'b0; pslverr = 1'b0; acc_cnt = 0; irq = 1'b0; irq_cnt = 0;
    end else begin
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) begin irq = 1'b1; t_irq = cyc; end
      end
      if (psel && penable) begin
        if (acc_cnt == ws) begin
          pready  = 1'b1;
          pslverr = err_on && pwrite && (paddr == err_addr);
          if (pwrite && paddr == 32'h0 && pwdata == 32'h5 && irq_dly != 0) irq_cnt = irq_dly;
          if (!pwrite && paddr == 32'h10) irq = 1'b0;
        end else begin
          pready = 1'b0; pslverr = 1'b0; acc_cnt++;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; acc_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every completed transfer and every done pulse.
  logic [31:0] su_addr, su_data;
  logic        su_wr, have_setup;
  logic [3:0]  gnt_prev;
  apb_t        e;
  done_t       d;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_setup = 1'b0;
      gnt_prev   = '0;
    end else begin
      if (psel && !penable) begin
        su_addr = paddr; su_wr = pwrite; su_data = pwdata; have_setup = 1'b1;
      end
      if (!psel) chk("bus_idle", {penable, |paddr, |pwdata}, 0);
      if (psel && penable && pready) begin
        chk("apb_setup_seen", 32'(have_setup), 1);
        chk("apb_stable", 32'(paddr == su_addr && pwrite == su_wr && pwdata == su_data), 1);
        have_setup = 1'b0;
        if (apb_q.size() == 0) begin
          chk("apb_unexpected", paddr, 32'hFFFF_FFFF);
        end else begin
          e = apb_q.pop_front();
          chk("apb_addr", paddr, e.addr);
          chk("apb_write", 32'(pwrite), 32'(e.wr));
          if (e.wr) chk("apb_wdata", pwdata, e.data);
        end
      end
      if (done != 0) begin
        chk("gnt_clear_at_done", 32'(gnt), 0);
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 0);
        end else begin
          d = done_q.pop_front();
          chk("done_vec", 32'(done), 32'(d.vec));
          chk("done_err", 32'(err), 32'(d.err));
        end
      end else begin
        chk("err_without_done", 32'(err), 0);
      end
      if (gnt != 0 && gnt != gnt_prev) begin
        chk("gnt_onehot", 32'($onehot(gnt)), 1);
        if (done_q.size() > 0) chk("gnt_owner", 32'(gnt), 32'(done_q[0].vec));
      end
      gnt_prev = gnt;
    end
  end

  task automatic set_slice(input int k, input logic [19:0] p, input logic [31:0] c);
    pscr[k*20 +: 20] = p;
    cmp[k*32 +: 32]  = c;
  endtask

  task automatic push_apb(input logic [31:0] a, input logic w, input logic [31:0] dt);
    apb_t t;
    t.addr = a; t.wr = w; t.data = dt;
    apb_q.push_back(t);
  endtask

  task automatic push_done(input int idx, input logic er);
    done_t t;
    t.vec = 4'(1 << idx); t.err = er;
    done_q.push_back(t);
  endtask

  task automatic push_normal(input int idx, input logic [19:0] p, input logic [31:0] c);
    push_apb(32'h04, 1'b1, {12'h0, p});
    push_apb(32'h0C, 1'b1, c);
    push_apb(32'h00, 1'b1, 32'h5);
    push_apb(32'h10, 1'b0, 32'h0);
    push_apb(32'h00, 1'b1, 32'h0);
    push_done(idx, 1'b0);
  endtask

  // Waits for n done pulses; drops all requests at the last one.
  task automatic wait_done(input int n, input int budget, output int t_last);
    int got = 0;
    t_last = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (done != 0) begin got++; t_last = cyc; end
    end
    if (got == n) req = 4'b0000;
    chk("done_count", got, n);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ctl"}, 32'({gnt, done, err, busy, psel, penable, pwrite}), 0);
    chk({name, "_paddr"}, paddr, 0);
    chk({name, "_pwdata"}, pwdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int t0, t_done;
    rst_n = 1'b1; req = '0; pscr = '0; cmp = '0; prdata = 32'hCAFE_0000;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round-robin with all four held: 0,1,2,3,0.
    for (int k = 0; k < 4; k++) set_slice(k, 20'h100 + 20'(k), 32'hA000_0000 + 32'(k));
    irq_dly = 2;
    for (int s = 0; s < 5; s++) push_normal(s % 4, 20'h100 + 20'(s % 4), 32'hA000_0000 + 32'(s % 4));
    req = 4'b1111;
    wait_done(5, 400, t_done);
    @(negedge clk);

    // Single requester with latency checks.
    set_slice(1, 20'd3, 32'd10);
    irq_dly = 4;
    push_normal(1, 20'd3, 32'd10);
    chk("idle_busy", 32'(busy), 0);
    req = 4'b0010;
    t0  = cyc;
    @(negedge clk);
    chk("lat_psel_n1", 32'({psel, penable}), 32'b10);
    chk("lat_paddr_n1", paddr, 32'h04);
    chk("lat_busy_n1", 32'(busy), 1);
    chk("lat_gnt_n1", 32'(gnt), 32'b0010);
    repeat (5) @(negedge clk);
    chk("lat_ctrl_n6_cycle", cyc - t0, 6);
    chk("lat_ctrl_n6_phase", 32'({psel, penable, pwrite, pready}), 32'b1111);
    chk("lat_ctrl_n6_addr", paddr, 32'h0);
    chk("lat_ctrl_n6_data", pwdata, 32'h5);
    wait_done(1, 100, t_done);
    chk("lat_irq_to_done", t_done - t_irq, 5);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);

    // Wait states and full-width prescaler zero extension.
    ws = 3;
    irq_dly = 3;
    set_slice(2, 20'hFFFFF, 32'hDEAD_BEEF);
    push_normal(2, 20'hFFFFF, 32'hDEAD_BEEF);
    req = 4'b0100;
    wait_done(1, 300, t_done);
    ws = 0;
    @(negedge clk);

    // Watchdog: no IRQ, no STAT read, timer disabled, error reported.
    irq_dly = 0;
    set_slice(3, 20'h7, 32'h1234);
    push_apb(32'h04, 1'b1, 32'h7);
    push_apb(32'h0C, 1'b1, 32'h1234);
    push_apb(32'h00, 1'b1, 32'h5);
    push_apb(32'h00, 1'b1, 32'h0);
    push_done(3, 1'b1);
    req = 4'b1000;
    t0  = cyc;
    wait_done(1, 200, t_done);
    chk("wdog_latency", t_done - t0, 29);
    @(negedge clk);

    // Slave error on CMP: CTRL arm skipped, disable still written.
    err_on = 1'b1;
    err_addr = 32'h0C;
    set_slice(0, 20'h55, 32'h77);
    push_apb(32'h04, 1'b1, 32'h55);
    push_apb(32'h0C, 1'b1, 32'h77);
    push_apb(32'h00, 1'b1, 32'h0);
    push_done(0, 1'b1);
    req = 4'b0001;
    wait_done(1, 100, t_done);
    err_on = 1'b0;
    @(negedge clk);

    // Reset while waiting for the IRQ, then a pending request from requester 0.
    irq_dly = 0;
    set_slice(2, 20'h9, 32'h99);
    push_apb(32'h04, 1'b1, 32'h9);
    push_apb(32'h0C, 1'b1, 32'h99);
    push_apb(32'h00, 1'b1, 32'h5);
    req = 4'b0100;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 1);
    rst_n = 1'b0;
    req   = 4'b0001;
    #1;
    chk_outputs_zero("async_reset");
    chk("reset_apb_drained", apb_q.size(), 0);
    irq_dly = 3;
    set_slice(0, 20'h21, 32'h321);
    push_normal(0, 20'h21, 32'h321);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(1, 100, t_done);

    repeat (3) @(negedge clk);
    chk("end_apb_q_empty", apb_q.size(), 0);
    chk("end_done_q_empty", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
